alu_dispatch: RTL and testbench

// - Issue stage that drives the ALU. It is the producer end of the ALU's
//   a/b/opr interface.
// - Accepts RV32I OP / OP-IMM instruction words plus register-file operand

---
 rtl/alu_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_alu_dispatch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: two-stage issue block in front of the ALU.
//   S1 decodes an RV32I OP / OP-IMM word, selects operands and drives the
//   ALU (alu_a/alu_b/alu_opr) straight from its registers.
//   S2 captures the ALU result and hands it to writeback over valid/ready.
// Optional feature: define ALU_DISPATCH_FWD_EN to forward in-flight results
// into the operands captured by S1 (S1 producer beats S2 producer).
module alu_dispatch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_opr,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic            s1_valid_r;
    logic [4:0]      s1_rd_r;
    logic            s1_illegal_r;

    logic            s1_load_s;
    logic            s2_load_s;

    logic [6:0]      opcode_s;
    logic [2:0]      f3_s;
    logic [6:0]      f7_s;
    logic [XLEN-1:0] shamt_s;
    logic [XLEN-1:0] imm_s;

    logic [XLEN-1:0] op1_s;
    logic [XLEN-1:0] op2_s;

    logic [XLEN-1:0] raw_a_s;
    logic [XLEN-1:0] raw_b_s;
    logic [3:0]      raw_opr_s;
    logic            legal_s;

    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;
    logic [3:0]      dec_opr_s;

    assign opcode_s = in_instr[6:0];
    assign f3_s     = in_instr[14:12];
    assign f7_s     = in_instr[31:25];
    assign shamt_s  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign imm_s    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    // S1 can take a new entry when it is empty or its entry moves on to S2.
    assign in_ready  = rst_n & (~s1_valid_r | ~out_valid | out_ready);
    assign s1_load_s = in_valid & in_ready;
    assign s2_load_s = s1_valid_r & (~out_valid | out_ready);

`ifdef ALU_DISPATCH_FWD_EN
    logic [4:0] rs1_idx_s;
    logic [4:0] rs2_idx_s;
    logic       s1_fwd_ok_s;
    logic       s2_fwd_ok_s;

    assign rs1_idx_s   = in_instr[19:15];
    assign rs2_idx_s   = in_instr[24:20];
    assign s1_fwd_ok_s = s1_valid_r & ~s1_illegal_r;
    assign s2_fwd_ok_s = out_valid & ~out_illegal;

    // rs1 operand: youngest legal in-flight producer wins, x0 never forwards.
    always_comb begin
        op1_s = in_rs1_val;
        if ((rs1_idx_s != 5'd0) && s1_fwd_ok_s && (s1_rd_r == rs1_idx_s)) begin
            op1_s = alu_result;
        end else if ((rs1_idx_s != 5'd0) && s2_fwd_ok_s && (out_rd == rs1_idx_s)) begin
            op1_s = out_result;
        end else begin
            op1_s = in_rs1_val;
        end
    end

    // rs2 operand: same priority as rs1.
    always_comb begin
        op2_s = in_rs2_val;
        if ((rs2_idx_s != 5'd0) && s1_fwd_ok_s && (s1_rd_r == rs2_idx_s)) begin
            op2_s = alu_result;
        end else if ((rs2_idx_s != 5'd0) && s2_fwd_ok_s && (out_rd == rs2_idx_s)) begin
            op2_s = out_result;
        end else begin
            op2_s = in_rs2_val;
        end
    end
`else
    // Source-register index bits only matter when forwarding is built in.
    logic unused_rs1_idx_s;
    assign unused_rs1_idx_s = ^in_instr[19:15];
    assign op1_s = in_rs1_val;
    assign op2_s = in_rs2_val;
`endif

    // Decode opcode/funct fields into operands, opr code and legality.
    always_comb begin
        raw_a_s   = op1_s;
        raw_b_s   = op2_s;
        raw_opr_s = {f7_s[5], f3_s};
        legal_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                raw_b_s   = op2_s;
                raw_opr_s = {f7_s[5], f3_s};
                legal_s   = (f7_s == F7_ZERO) ||
                            ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
            end
            OPC_OP_IMM: begin
                case (f3_s)
                    3'b001: begin
                        raw_b_s   = shamt_s;
                        raw_opr_s = 4'b0001;
                        legal_s   = (f7_s == F7_ZERO);
                    end
                    3'b101: begin
                        raw_b_s   = shamt_s;
                        raw_opr_s = {f7_s[5], 3'b101};
                        legal_s   = (f7_s == F7_ZERO) || (f7_s == F7_ALT);
                    end
                    default: begin
                        raw_b_s   = imm_s;
                        raw_opr_s = {1'b0, f3_s};
                        legal_s   = 1'b1;
                    end
                endcase
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // Illegal encodings still flow down the pipe, but as a harmless 0+0.
    always_comb begin
        dec_a_s   = {XLEN{1'b0}};
        dec_b_s   = {XLEN{1'b0}};
        dec_opr_s = 4'b0000;
        if (legal_s) begin
            dec_a_s   = raw_a_s;
            dec_b_s   = raw_b_s;
            dec_opr_s = raw_opr_s;
        end else begin
            dec_a_s   = {XLEN{1'b0}};
            dec_b_s   = {XLEN{1'b0}};
            dec_opr_s = 4'b0000;
        end
    end

    // Stage 1: capture decoded entry on input handshake, empty when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            alu_a        <= {XLEN{1'b0}};
            alu_b        <= {XLEN{1'b0}};
            alu_opr      <= 4'b0000;
            s1_rd_r      <= 5'd0;
            s1_illegal_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r   <= 1'b1;
            alu_a        <= dec_a_s;
            alu_b        <= dec_b_s;
            alu_opr      <= dec_opr_s;
            s1_rd_r      <= in_instr[11:7];
            s1_illegal_r <= ~legal_s;
        end else if (s2_load_s) begin
            s1_valid_r   <= 1'b0;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    // Stage 2: capture ALU result; hold while writeback stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rd      <= 5'd0;
            out_result  <= {XLEN{1'b0}};
            out_illegal <= 1'b0;
        end else if (s2_load_s) begin
            out_valid   <= 1'b1;
            out_rd      <= s1_rd_r;
            out_result  <= s1_illegal_r ? {XLEN{1'b0}} : alu_result;
            out_illegal <= s1_illegal_r;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch with a behavioural ALU and a
// scoreboard of expected writeback entries.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opr;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
        logic [3:0]  opr;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[11];

    alu_dispatch #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opr    (alu_opr),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural RV32I ALU on the opr = {funct7[5], funct3} code.
    always_comb begin
        alu_result = 32'd0;
        case (alu_opr)
            4'b0000: alu_result = alu_a + alu_b;
            4'b1000: alu_result = alu_a - alu_b;
            4'b0001: alu_result = alu_a << alu_b[4:0];
            4'b0010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0011: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a >> alu_b[4:0];
            4'b1101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Writeback monitor: every output handshake is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
                check("out_result", out_result, mon_e.res);
                check("out_illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1v,
                         input logic [31:0] rs2v, input logic [4:0] rd,
                         input logic [31:0] res, input logic ill);
        int   n;
        logic acc;
        n          = 0;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = rs1v;
        in_rs2_val = rs2v;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb_q.push_back('{rd: rd, res: res, ill: ill});
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        while ((out_valid || sb_q.size() != 0) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", sb_q.size(), 32'd0);
    endtask

    task automatic load_bp(input int k);
        in_instr   = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'(20 + k));
        in_rs1_val = 32'(100 + k);
        in_rs2_val = 32'(k);
    endtask

    initial begin
        int   k;
        logic acc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = 32'd0;
        in_rs1_val = 32'd0;
        in_rs2_val = 32'd0;
        out_ready  = 1'b1;

        //                instr                                  rs1           rs2           rd     res           ill   opr      a             b
        vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),   32'd10,       32'd5,        5'd3,  32'd15,       1'b0, 4'b0000, 32'd10,       32'd5};
        vecs[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3),   32'd10,       32'd5,        5'd3,  32'd5,        1'b0, 4'b1000, 32'd10,       32'd5};
        vecs[2]  = '{enc_i(12'h402, 5'd6, 3'b101, 5'd5),       32'hFFFFFFF8, 32'h1234,     5'd5,  32'hFFFFFFFE, 1'b0, 4'b1101, 32'hFFFFFFF8, 32'd2};
        vecs[3]  = '{enc_i(12'h001, 5'd1, 3'b011, 5'd7),       32'hFFFFFFFF, 32'd0,        5'd7,  32'd0,        1'b0, 4'b0011, 32'hFFFFFFFF, 32'd1};
        vecs[4]  = '{enc_i(12'h004, 5'd1, 3'b001, 5'd8),       32'd3,        32'd99,       5'd8,  32'h30,       1'b0, 4'b0001, 32'd3,        32'd4};
        vecs[5]  = '{enc_i(12'hFFF, 5'd1, 3'b000, 5'd9),       32'd10,       32'd0,        5'd9,  32'd9,        1'b0, 4'b0000, 32'd10,       32'hFFFFFFFF};
        vecs[6]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10),  32'hF0F0,     32'h0FF0,     5'd10, 32'hFF00,     1'b0, 4'b0100, 32'hF0F0,     32'h0FF0};
        vecs[7]  = '{32'h0000007F,                             32'h55,       32'h66,       5'd0,  32'd0,        1'b1, 4'b0000, 32'd0,        32'd0};
        vecs[8]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'b100, 5'd11),  32'd10,       32'd5,        5'd11, 32'd0,        1'b1, 4'b0000, 32'd0,        32'd0};
        vecs[9]  = '{enc_i(12'h404, 5'd1, 3'b001, 5'd12),      32'd3,        32'd0,        5'd12, 32'd0,        1'b1, 4'b0000, 32'd0,        32'd0};
        vecs[10] = '{enc_i(12'h004, 5'd1, 3'b101, 5'd13),      32'h80000000, 32'd0,        5'd13, 32'h08000000, 1'b0, 4'b0101, 32'h80000000, 32'd4};

        // Reset state.
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-issue decode vectors with latency check.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].res, vecs[i].ill);
            check($sformatf("opr_%0d", i), {28'd0, alu_opr}, {28'd0, vecs[i].opr});
            check($sformatf("alu_a_%0d", i), alu_a, vecs[i].a);
            check($sformatf("alu_b_%0d", i), alu_b, vecs[i].b);
            check($sformatf("lat1_%0d", i), {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("lat2_%0d", i), {31'd0, out_valid}, 32'd1);
            drain();
        end

        // Backpressure: 4 back-to-back ADDs, writeback stalled for 5 cycles.
        out_ready = 1'b0;
        k         = 0;
        load_bp(0);
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sb_q.push_back('{rd: 5'(20 + k), res: 32'(100 + 2 * k), ill: 1'b0});
            if (c >= 2) begin
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_hold_rd", {27'd0, out_rd}, 32'd20);
                check("bp_hold_result", out_result, 32'd100);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 4) load_bp(k);
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts", 32'(k), 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sb_q.push_back('{rd: 5'(20 + k), res: 32'(100 + 2 * k), ill: 1'b0});
            check("bp_stream_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 4) load_bp(k);
                else in_valid = 1'b0;
            end
        end
        check("bp_total", 32'(k), 32'd4);
        drain();

        // Reset with both stages full: everything in flight is discarded.
        out_ready = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 32'd1, 32'd2, 5'd14, 32'd3, 1'b0);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd15), 32'd4, 32'd5, 5'd15, 32'd9, 1'b0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back dependency: ADDI x1,x0,7 then ADD x2,x1,x1.
        issue(enc_i(12'd7, 5'd0, 3'b000, 5'd1), 32'd0, 32'd0, 5'd1, 32'd7, 1'b0);
`ifdef ALU_DISPATCH_FWD_EN
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'd0, 32'd0, 5'd2, 32'd14, 1'b0);
`else
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'd0, 32'd0, 5'd2, 32'd0, 1'b0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
